// File: rtl/eq_pkg.sv
// Purpose : shared register map, bit positions, reset constants and FSM encoding
//           for the equalizer coefficient scheduler.
// Latency : n/a (declarations only). Backpressure: n/a.
package eq_pkg;

    localparam int GAIN_W = 16;

    // Register word indices (byte address bits [5:2])
    localparam logic [3:0] WORD_CTRL      = 4'd8;
    localparam logic [3:0] WORD_STATUS    = 4'd9;
    localparam logic [3:0] WORD_RAMP_STEP = 4'd10;

    // CTRL bit positions
    localparam int CTRL_COMMIT_BIT = 0;
    localparam int CTRL_BYPASS_BIT = 1;

    // STATUS bit positions
    localparam int STATUS_PENDING_BIT = 0;
    localparam int STATUS_BUSY_BIT    = 1;
    localparam int STATUS_CNT_LSB     = 8;

    // Reset constants
    localparam logic [GAIN_W-1:0] GAIN_RESET       = 16'h4000;  // +1.0 in Q2.14
    localparam logic [GAIN_W-1:0] RAMP_STEP_RESET  = 16'h0100;
    localparam logic [7:0]        COMMIT_CNT_RESET = 8'd0;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_STRB = 2'd1,
        ST_RAMP      = 2'd2
    } eq_state_t;

    // Byte address to 32-bit word index
    function automatic logic [3:0] word_index(input logic [5:0] byte_addr);
        return byte_addr[5:2];
    endfunction

endpackage

// File: rtl/eq_gain_stepper.sv
// Purpose : one band's ramp step: moves active toward target by at most step.
// Latency : purely combinational. Backpressure: none.
// Ports   : active/target (signed Q2.14), step (unsigned) in; next_gain, at_target out.
module eq_gain_stepper
    import eq_pkg::*;
(
    input  logic [GAIN_W-1:0] active,
    input  logic [GAIN_W-1:0] target,
    input  logic [GAIN_W-1:0] step,
    output logic [GAIN_W-1:0] next_gain,
    output logic              at_target
);

    logic [GAIN_W:0] diff;   // target - active, 17-bit two's complement
    logic [GAIN_W:0] mag;    // |diff|, at most 65535 so fits unsigned 17-bit

    always_comb begin
        // Sign-extend both operands; the true difference always fits in 17 bits.
        diff = {target[GAIN_W-1], target} - {active[GAIN_W-1], active};
        mag  = diff[GAIN_W] ? (~diff + 17'd1) : diff;

        // A zero step means jump straight to target. When |diff| > step the
        // move cannot overshoot, so 16-bit modular add/sub stays in range.
        if ((step == '0) || (mag <= {1'b0, step})) begin
            next_gain = target;
        end else if (diff[GAIN_W]) begin
            next_gain = active - step;
        end else begin
            next_gain = active + step;
        end

        at_target = (next_gain == target);
    end

endmodule

// File: rtl/eq_coef_scheduler.sv
// Purpose : register bank of shadow EQ gains with glitch-free, sample-aligned
//           commit: snapshot to targets, then ramp active gains one step per sample.
// Latency : shadow writes visible next cycle; reads combinational; active gains move
//           on sample_strobe edges only. Backpressure: none; commits during a ramp
//           coalesce into a single PENDING request.
// Ports   : simple write/read bus (wrAddr/wrData/wr, rdAddr/rdData/rd),
//           sample_strobe in; gain_active, bypass_active, commit_done out.
module eq_coef_scheduler
    import eq_pkg::*;
#(
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int NUM_BANDS          = 8
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] wrAddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0] wrData,
    input  logic                          wr,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0] rdAddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0] rdData,
    input  logic                          rd,
    input  logic                          sample_strobe,
    output logic [16*NUM_BANDS-1:0]       gain_active,
    output logic                          bypass_active,
    output logic                          commit_done
);

    logic [GAIN_W-1:0] shadow_gain [NUM_BANDS];
    logic [GAIN_W-1:0] target_gain [NUM_BANDS];
    logic [GAIN_W-1:0] active_gain [NUM_BANDS];
    logic [GAIN_W-1:0] step_gain   [NUM_BANDS];
    logic [NUM_BANDS-1:0] band_done;

    logic              bypass_shadow;
    logic [GAIN_W-1:0] ramp_step;
    logic              pending;
    logic [7:0]        commit_cnt;

    eq_state_t state;
    eq_state_t state_nxt;

    logic [3:0] wr_word;
    logic [3:0] rd_word;
    logic       commit_wr;
    logic       busy;
    logic       take_snapshot;
    logic       apply_step;
    logic       load_bypass;
    logic       finish;

    // Address bits outside the word index and the informational rd strobe
    // carry no function here.
    logic unused_inputs;
    assign unused_inputs = ^{rd, wrAddr, rdAddr, wrData};

    assign wr_word   = word_index(wrAddr[5:0]);
    assign rd_word   = word_index(rdAddr[5:0]);
    assign commit_wr = wr && (wr_word == WORD_CTRL) && wrData[CTRL_COMMIT_BIT];
    assign busy      = (state != ST_IDLE);

    // ------------------------------------------------------------------
    // Per-band step arithmetic
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
        eq_gain_stepper u_stepper (
            .active    (active_gain[g]),
            .target    (target_gain[g]),
            .step      (ramp_step),
            .next_gain (step_gain[g]),
            .at_target (band_done[g])
        );
        assign gain_active[16*g +: 16] = active_gain[g];
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt     = state;
        take_snapshot = 1'b0;
        apply_step    = 1'b0;
        load_bypass   = 1'b0;
        finish        = 1'b0;

        case (state)
            ST_IDLE: begin
                if (commit_wr || pending) begin
                    take_snapshot = 1'b1;
                    state_nxt     = ST_WAIT_STRB;
                end
            end
            ST_WAIT_STRB: begin
                if (sample_strobe) begin
                    apply_step  = 1'b1;
                    load_bypass = 1'b1;
                    if (&band_done) begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RAMP;
                    end
                end
            end
            ST_RAMP: begin
                if (sample_strobe) begin
                    apply_step = 1'b1;
                    if (&band_done) begin
                        finish    = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register bank, targets, active gains, status
    // ------------------------------------------------------------------
    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            for (int b = 0; b < NUM_BANDS; b++) begin
                shadow_gain[b] <= GAIN_RESET;
                target_gain[b] <= GAIN_RESET;
                active_gain[b] <= GAIN_RESET;
            end
            bypass_shadow <= 1'b0;
            bypass_active <= 1'b0;
            ramp_step     <= RAMP_STEP_RESET;
            pending       <= 1'b0;
            commit_cnt    <= COMMIT_CNT_RESET;
            commit_done   <= 1'b0;
        end else begin
            if (wr) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    if (int'(wr_word) == b) begin
                        shadow_gain[b] <= wrData[GAIN_W-1:0];
                    end
                end
                if (wr_word == WORD_CTRL) begin
                    bypass_shadow <= wrData[CTRL_BYPASS_BIT];
                end
                if (wr_word == WORD_RAMP_STEP) begin
                    ramp_step <= wrData[GAIN_W-1:0];
                end
            end

            // Snapshot only happens in IDLE and PENDING only sets while busy,
            // so the two never collide.
            if (take_snapshot) begin
                pending <= 1'b0;
            end else if (commit_wr && busy) begin
                pending <= 1'b1;
            end

            if (take_snapshot) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    target_gain[b] <= shadow_gain[b];
                end
            end

            if (apply_step) begin
                for (int b = 0; b < NUM_BANDS; b++) begin
                    active_gain[b] <= step_gain[b];
                end
            end

            if (load_bypass) begin
                bypass_active <= bypass_shadow;
            end

            commit_done <= finish;
            if (finish) begin
                commit_cnt <= commit_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux: combinational, so a same-cycle write returns the old value
    // ------------------------------------------------------------------
    always_comb begin
        rdData = '0;
        for (int b = 0; b < NUM_BANDS; b++) begin
            if (int'(rd_word) == b) begin
                rdData[GAIN_W-1:0] = shadow_gain[b];
            end
        end
        if (rd_word == WORD_CTRL) begin
            rdData[CTRL_BYPASS_BIT] = bypass_shadow;
        end
        if (rd_word == WORD_STATUS) begin
            rdData[STATUS_PENDING_BIT]              = pending;
            rdData[STATUS_BUSY_BIT]                 = busy;
            rdData[STATUS_CNT_LSB +: 8]             = commit_cnt;
        end
        if (rd_word == WORD_RAMP_STEP) begin
            rdData[GAIN_W-1:0] = ramp_step;
        end
    end

endmodule
